// File: rtl/servo_pkg.sv
// Shared constants, width type and clamp helper for the servo PWM block.
// Optional feature macro: SERVO_SLEW_LIMIT_EN (slew-limited width changes).
package servo_pkg;

    localparam int unsigned SERVO_CNT_W          = 20;
    localparam int unsigned SERVO_PERIOD_DEFAULT = 240000;
    localparam int unsigned SERVO_MIN_DEFAULT    = 12000;
    localparam int unsigned SERVO_MAX_DEFAULT    = 24000;
    localparam int unsigned SERVO_STEP_DEFAULT   = 240;

    typedef logic [SERVO_CNT_W-1:0] servo_w_t;

    // Zero stays zero (channel off); nonzero requests are forced into [min_w, max_w].
    function automatic logic [31:0] servo_clamp(input logic [31:0] data,
                                                input logic [31:0] min_w,
                                                input logic [31:0] max_w);
        logic [31:0] res;
        res = data;
        if (data == 32'd0) begin
            res = 32'd0;
        end else if (data < min_w) begin
            res = min_w;
        end else if (data > max_w) begin
            res = max_w;
        end
        return res;
    endfunction

endpackage

// File: rtl/servo_chan.sv
// One servo channel: holds the pending target and the width in use this frame,
// and drives its registered PWM bit from the shared frame counter.
// Optional feature macro: SERVO_SLEW_LIMIT_EN (limit width change per frame to STEP).
module servo_chan
    import servo_pkg::*;
#(
    parameter int unsigned CNT_W = SERVO_CNT_W,
    parameter int unsigned MIN_W = SERVO_MIN_DEFAULT,
    parameter int unsigned MAX_W = SERVO_MAX_DEFAULT,
    parameter int unsigned STEP  = SERVO_STEP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [CNT_W-1:0] wr_data_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic             srv_o
);

    if (STEP == 0 || MIN_W > MAX_W) begin : g_param_err
        $error("servo_chan: need STEP > 0 and MIN_W <= MAX_W");
    end

    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] wr_clamped;
    logic [CNT_W-1:0] next_w;
    logic             srv_q, srv_d;

    assign wr_clamped = CNT_W'(servo_clamp(32'(wr_data_i), MIN_W, MAX_W));

`ifdef SERVO_SLEW_LIMIT_EN
    localparam logic [CNT_W-1:0] StepW = CNT_W'(STEP);

    // Move toward target by at most StepW; power-up and switch-off jump immediately.
    always_comb begin
        next_w = target_q;
        if (active_q != '0 && target_q != '0) begin
            if (target_q > active_q) begin
                if (target_q - active_q > StepW) begin
                    next_w = active_q + StepW;
                end
            end else if (active_q - target_q > StepW) begin
                next_w = active_q - StepW;
            end
        end
    end
`else
    assign next_w = target_q;
`endif

    // Target follows accepted writes; active only changes on the frame-boundary strobe.
    always_comb begin
        target_d = target_q;
        active_d = active_q;
        if (wr_en_i) begin
            target_d = wr_clamped;
        end
        if (load_i) begin
            active_d = next_w;
        end
        srv_d = (cnt_i < active_q);
    end

    // Channel state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            target_q <= '0;
            active_q <= '0;
            srv_q    <= 1'b0;
        end else begin
            target_q <= target_d;
            active_q <= active_d;
            srv_q    <= srv_d;
        end
    end

    assign srv_o = srv_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator: shared frame counter, valid/ready width
// write port, per-channel clamp and frame-boundary apply, sticky bad-channel flag.
// Optional feature macro: SERVO_SLEW_LIMIT_EN (slew-limited width changes).
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int unsigned CH     = 4,
    parameter int unsigned CNT_W  = SERVO_CNT_W,
    parameter int unsigned PERIOD = SERVO_PERIOD_DEFAULT,
    parameter int unsigned MIN_W  = SERVO_MIN_DEFAULT,
    parameter int unsigned MAX_W  = SERVO_MAX_DEFAULT,
    parameter int unsigned STEP   = SERVO_STEP_DEFAULT,
    // Wide enough to carry the value CH so out-of-range indices can be flagged.
    parameter int unsigned CH_W   = $clog2(CH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pos_valid,
    output logic             pos_ready,
    input  logic [CH_W-1:0]  pos_ch,
    input  logic [CNT_W-1:0] pos_data,
    output logic [CH-1:0]    srv_o,
    output logic             frame_sync,
    output logic             err
);

    if (CH < 2 || MIN_W > MAX_W || MAX_W >= PERIOD || PERIOD < 2 ||
        ((PERIOD - 1) >> CNT_W) != 0) begin : g_param_err
        $error("servo_pwm_multi: need CH>=2 and MIN_W<=MAX_W<PERIOD<2**CNT_W");
    end

    localparam logic [CNT_W-1:0] CntLast    = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CntPreLast = CNT_W'(PERIOD - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fs_q, fs_d;
    logic             err_q, err_d;
    logic             boundary;
    logic             wr_fire;
    logic             ch_ok;
    logic [CH-1:0]    wr_en;

    assign boundary  = (cnt_q == CntLast);
    // Writes are refused on the boundary cycle so a load never races a target update.
    assign pos_ready = ~boundary;
    assign wr_fire   = pos_valid & pos_ready;
    assign ch_ok     = (pos_ch < CH_W'(CH));

    // Frame counter, frame-sync look-ahead and sticky error next-state.
    always_comb begin
        cnt_d = boundary ? '0 : cnt_q + CNT_W'(1);
        fs_d  = (cnt_q == CntPreLast);
        err_d = err_q | (wr_fire & ~ch_ok);
    end

    // Decode the accepted write onto one channel; out-of-range indices hit nothing.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < CH; i++) begin
            wr_en[i] = wr_fire && (pos_ch == CH_W'(i));
        end
    end

    // Shared frame state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            fs_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            fs_q  <= fs_d;
            err_q <= err_d;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_chan
        servo_chan #(
            .CNT_W (CNT_W),
            .MIN_W (MIN_W),
            .MAX_W (MAX_W),
            .STEP  (STEP)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (wr_en[i]),
            .wr_data_i (pos_data),
            .load_i    (boundary),
            .cnt_i     (cnt_q),
            .srv_o     (srv_o[i])
        );
    end

    assign frame_sync = fs_q;
    assign err        = err_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Scoreboard bench for servo_pwm_multi: a reference model pushes the expected
// per-channel widths at each frame boundary; a monitor measures each frame's
// pulses and pops/compares. Honours SERVO_SLEW_LIMIT_EN like the design.
module tb_servo_pwm_multi;

    localparam int unsigned CH     = 4;
    localparam int unsigned CNT_W  = 20;
    localparam int unsigned PERIOD = 100;
    localparam int unsigned MIN_W  = 10;
    localparam int unsigned MAX_W  = 90;
    localparam int unsigned STEP   = 5;

    typedef logic [CH-1:0][CNT_W-1:0] wv_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             pos_valid;
    logic             pos_ready;
    logic [2:0]       pos_ch;
    logic [CNT_W-1:0] pos_data;
    logic [CH-1:0]    srv_o;
    logic             frame_sync;
    logic             err;

    int n_chk = 0;
    int n_err = 0;

    servo_pwm_multi #(
        .CH     (CH),
        .CNT_W  (CNT_W),
        .PERIOD (PERIOD),
        .MIN_W  (MIN_W),
        .MAX_W  (MAX_W),
        .STEP   (STEP)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .pos_valid  (pos_valid),
        .pos_ready  (pos_ready),
        .pos_ch     (pos_ch),
        .pos_data   (pos_data),
        .srv_o      (srv_o),
        .frame_sync (frame_sync),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] mclamp(input logic [CNT_W-1:0] d);
        if (d == 0) return '0;
        if (d < CNT_W'(MIN_W)) return CNT_W'(MIN_W);
        if (d > CNT_W'(MAX_W)) return CNT_W'(MAX_W);
        return d;
    endfunction

    function automatic logic [CNT_W-1:0] mnext(input logic [CNT_W-1:0] t,
                                               input logic [CNT_W-1:0] a);
`ifdef SERVO_SLEW_LIMIT_EN
        if (a == 0 || t == 0) return t;
        if (t > a + CNT_W'(STEP)) return a + CNT_W'(STEP);
        if (a > t + CNT_W'(STEP)) return a - CNT_W'(STEP);
        return t;
`else
        return t;
`endif
    endfunction

    function automatic wv_t next_all(input wv_t t, input wv_t a);
        wv_t r;
        for (int i = 0; i < CH; i++) r[i] = mnext(t[i], a[i]);
        return r;
    endfunction

    // Reference model
    int   m_cnt;
    wv_t  m_tgt;
    wv_t  m_act;
    logic m_err;
    wv_t  exp_q[$];

    always @(posedge clk) begin
        if (rst) begin
            m_cnt <= 0;
            m_tgt <= '0;
            m_act <= '0;
            m_err <= 1'b0;
            exp_q.delete();
            exp_q.push_back('0);
        end else begin
            if (pos_valid && m_cnt != PERIOD - 1) begin
                if (pos_ch < 3'(CH)) m_tgt[pos_ch[1:0]] <= mclamp(pos_data);
                else m_err <= 1'b1;
            end
            if (m_cnt == PERIOD - 1) begin
                m_cnt <= 0;
                m_act <= next_all(m_tgt, m_act);
                exp_q.push_back(next_all(m_tgt, m_act));
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // Monitor: per-cycle handshake/sync checks and per-frame width measurement
    int hi [CH];

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) hi[i] <= 0;
        end else begin
            chk("pos_ready", 32'(pos_ready), 32'(m_cnt != PERIOD - 1));
            chk("frame_sync", 32'(frame_sync), 32'(m_cnt == PERIOD - 1));
            if (m_cnt == 0) chk("srv_at_cnt0", 32'(srv_o), 0);
            if (m_cnt == PERIOD - 1) begin
                chk("err_flag", 32'(err), 32'(m_err));
                chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    for (int i = 0; i < CH; i++) begin
                        chk($sformatf("width_ch%0d", i), 32'(hi[i] + int'(srv_o[i])),
                            32'(exp_q[0][i]));
                    end
                    void'(exp_q.pop_front());
                end
                for (int i = 0; i < CH; i++) hi[i] <= 0;
            end else begin
                for (int i = 0; i < CH; i++) hi[i] <= hi[i] + int'(srv_o[i]);
            end
        end
    end

    task automatic wr(input logic [2:0] ch, input logic [CNT_W-1:0] d, output int waits);
        logic rdy;
        rdy       = 1'b0;
        waits     = 0;
        pos_ch    = ch;
        pos_data  = d;
        pos_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rdy = pos_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waits++;
        end
        pos_valid = 1'b0;
        chk("wr_accept", 32'(rdy), 1);
    endtask

    task automatic wait_cnt(input int v);
        for (int k = 0; k < 2 * PERIOD; k++) begin
            @(posedge clk);
            #1;
            if (m_cnt == v) break;
        end
    endtask

    task automatic wait_frames(input int n);
        repeat (n * PERIOD) @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        rst       = 1'b1;
        pos_valid = 1'b0;
        pos_ch    = '0;
        pos_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_srv", 32'(srv_o), 0);
        chk("rst_fs", 32'(frame_sync), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ready", 32'(pos_ready), 1);

        // Idle frames: all outputs stay low
        wait_frames(3);

        // Mid-frame write applies from the next frame
        wait_cnt(50);
        wr(3'd1, 20'd40, w);
        wait_frames(3);

        // Clamp floor and ceiling
        wait_cnt(20);
        wr(3'd0, 20'd5, w);
        wr(3'd2, 20'd200, w);
        wait_frames(2);

        // Write held across the boundary cycle is taken at cnt==0
        wait_cnt(PERIOD - 1);
        wr(3'd3, 20'd60, w);
        chk("hold_wait", 32'(w), 1);
        wait_frames(3);

        // Out-of-range channel: dropped, sticky error
        wait_cnt(10);
        wr(3'd4, 20'd33, w);
        chk("err_set", 32'(err), 1);
        wait_frames(2);

        // Channel off, then slew sequence on ch3
        wr(3'd1, 20'd0, w);
        wr(3'd3, 20'd0, w);
        wait_frames(2);
        wait_cnt(40);
        wr(3'd3, 20'd20, w);
        wait_frames(2);
        wr(3'd3, 20'd40, w);
        wait_frames(6);
        wr(3'd3, 20'd0, w);
        wait_frames(2);

        // Mid-frame reset discards a pending target and clears everything
        wr(3'd2, 20'd30, w);
        wait_cnt(20);
        wr(3'd0, 20'd50, w);
        wait_cnt(30);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_srv", 32'(srv_o), 0);
        chk("mid_rst_fs", 32'(frame_sync), 0);
        chk("mid_rst_err", 32'(err), 0);
        wait_frames(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
